// File: rtl/pingpong_sram_ctrl.sv
// Ping-pong sequencer for a dual-bank SRAM pair: each pass writes one bank while
// reading the same addresses from the other bank, and swaps the roles at pass end.
module pingpong_sram_ctrl #(
  parameter int data_width = 16,
  parameter int addr_width = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [addr_width:0]   len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in_data,
  output logic                  out_valid,
  output logic [data_width-1:0] out_data,
  output logic                  busy,
  output logic                  done,
  output logic                  bank_sel,
  output logic                  cs1,
  output logic                  cs2,
  output logic                  oe1,
  output logic                  oe2,
  output logic                  we1,
  output logic                  we2,
  output logic [addr_width-1:0] addr,
  inout  wire  [data_width-1:0] data1,
  inout  wire  [data_width-1:0] data2
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [addr_width-1:0] r_cnt;
  logic [addr_width:0]   r_len;
  logic                  r_bank;
  logic                  r_first;
  logic                  r_zero;
  logic                  r_out_valid;
  logic [data_width-1:0] r_out_data;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_rd;
  logic [data_width-1:0] w_rd_bus;

  assign w_accept = (r_state == S_RUN) && in_valid;
  assign w_last   = ({1'b0, r_cnt} == (r_len - 1'b1));
  assign w_rd     = w_accept && !r_first;
  // Read bank is the one not being written.
  assign w_rd_bus = r_bank ? data1 : data2;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (len != '0) ? S_RUN : S_DONE;
      S_RUN:   if (w_accept && w_last) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    cs1 = 1'b0; cs2 = 1'b0;
    oe1 = 1'b0; oe2 = 1'b0;
    we1 = 1'b0; we2 = 1'b0;
    if (w_accept) begin
      if (!r_bank) begin
        cs1 = 1'b1; we1 = 1'b1;
        cs2 = !r_first; oe2 = !r_first;
      end else begin
        cs2 = 1'b1; we2 = 1'b1;
        cs1 = !r_first; oe1 = !r_first;
      end
    end
  end

  assign data1     = we1 ? in_data : 'z;
  assign data2     = we2 ? in_data : 'z;
  assign in_ready  = (r_state == S_RUN);
  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign bank_sel  = r_bank;
  assign addr      = r_cnt;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_bank      <= 1'b0;
      r_first     <= 1'b1;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_next;
      r_out_valid <= w_rd;
      if (w_rd) r_out_data <= w_rd_bus;
      if (r_state == S_IDLE && start) begin
        r_len  <= len;
        r_cnt  <= '0;
        r_zero <= (len == '0);
      end
      // Hold cnt on the last word so addr never wraps for a full-depth pass.
      if (w_accept && !w_last) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_DONE && !r_zero) begin
        r_bank  <= ~r_bank;
        r_first <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_sram_ctrl.sv
// Directed bench for pingpong_sram_ctrl with behavioural async-read SRAM banks.
module tb_pingpong_sram_ctrl;
  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst, start, in_valid;
  logic [AW:0]   len;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, busy, done, bank_sel;
  logic [DW-1:0] out_data;
  logic          cs1, cs2, oe1, oe2, we1, we2;
  logic [AW-1:0] addr;
  wire  [DW-1:0] data1, data2;

  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic [DW-1:0] mem2 [0:(1<<AW)-1];

  int n_tests = 0, n_fail = 0;
  int n_we1, n_we2, n_rd_cs, n_ov, n_done, n_wr_pass;
  int last_wr_addr;
  bit prev_rd = 1'b0;
  logic [DW-1:0] exp_q [$];

  pingpong_sram_ctrl #(.data_width(DW), .addr_width(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .done(done), .bank_sel(bank_sel),
    .cs1(cs1), .cs2(cs2), .oe1(oe1), .oe2(oe2), .we1(we1), .we2(we2),
    .addr(addr), .data1(data1), .data2(data2)
  );

  always #5 clk = ~clk;

  assign data1 = (cs1 && oe1 && !we1) ? mem1[addr] : 'z;
  assign data2 = (cs2 && oe2 && !we2) ? mem2[addr] : 'z;

  always @(posedge clk) begin
    if (cs1 && we1) mem1[addr] <= data1;
    if (cs2 && we2) mem2[addr] <= data2;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Per-cycle protocol checks and event counting, sampled mid-cycle.
  always @(negedge clk) begin
    if (we1) chk("drv1", 64'(data1), 64'(in_data));
    else if (!(cs1 && oe1)) chk("z1", 64'(data1 === 16'hzzzz), 64'd1);
    if (we2) chk("drv2", 64'(data2), 64'(in_data));
    else if (!(cs2 && oe2)) chk("z2", 64'(data2 === 16'hzzzz), 64'd1);
    if (we1 && oe1) chk("weoe1", 64'd1, 64'd0);
    if (we2 && oe2) chk("weoe2", 64'd1, 64'd0);
    chk("ov_lat", 64'(out_valid), 64'(prev_rd));
    prev_rd = (cs1 && oe1 && !we1) || (cs2 && oe2 && !we2);
    if (in_ready && !in_valid) begin
      chk("gap_cs", 64'({cs1, cs2, oe1, oe2, we1, we2}), 64'd0);
      chk("gap_addr", 64'(addr), 64'(n_wr_pass));
    end
    if (we1 || we2) begin
      chk("wr_addr", 64'(addr), 64'(n_wr_pass));
      last_wr_addr = int'(addr);
      n_wr_pass++;
    end
    if (we1) n_we1++;
    if (we2) n_we2++;
    if ((cs1 && !we1) || (cs2 && !we2)) n_rd_cs++;
    if (done) n_done++;
    if (out_valid) begin
      n_ov++;
      if (exp_q.size() == 0) chk("ov_unexp", 64'd1, 64'd0);
      else chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
    end
  end

  task automatic clr();
    n_we1 = 0; n_we2 = 0; n_rd_cs = 0; n_ov = 0; n_done = 0; n_wr_pass = 0;
  endtask

  task automatic run_pass(input int n, input logic [DW-1:0] base, input bit gaps);
    bit [4:0] pat;
    int sent, k;
    bit acc, got;
    pat = 5'b11001;
    n_wr_pass = 0;
    start = 1'b1; len = (AW+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    sent = 0; k = 0;
    while (sent < n && k < 5000) begin
      in_valid = (gaps && k < 5) ? pat[k] : 1'b1;
      in_data  = base + DW'(sent);
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) sent++;
      #1; k++;
    end
    in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = done;
    end
    chk("done_seen", 64'(got), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    clr();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", 64'({in_ready, out_valid, busy, done, bank_sel, cs1, cs2, oe1, oe2, we1, we2}), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_odata", 64'(out_data), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: first pass writes bank1, nothing read
    clr();
    run_pass(4, 16'hA000, 1'b0);
    chk("t1_we1", 64'(n_we1), 64'd4);
    chk("t1_we2", 64'(n_we2), 64'd0);
    chk("t1_rdcs", 64'(n_rd_cs), 64'd0);
    chk("t1_ov", 64'(n_ov), 64'd0);
    chk("t1_done", 64'(n_done), 64'd1);
    chk("t1_bank", 64'(bank_sel), 64'd1);
    chk("t1_mem0", 64'(mem1[0]), 64'hA000);
    chk("t1_mem3", 64'(mem1[3]), 64'hA003);

    // T2: write bank2, read back A0..A3 from bank1
    clr();
    for (int i = 0; i < 4; i++) exp_q.push_back(16'hA000 + 16'(i));
    run_pass(4, 16'hB000, 1'b0);
    chk("t2_we2", 64'(n_we2), 64'd4);
    chk("t2_we1", 64'(n_we1), 64'd0);
    chk("t2_ov", 64'(n_ov), 64'd4);
    chk("t2_q", 64'(exp_q.size()), 64'd0);
    chk("t2_done", 64'(n_done), 64'd1);
    chk("t2_bank", 64'(bank_sel), 64'd0);

    // T3: stalled input stream
    clr();
    for (int i = 0; i < 3; i++) exp_q.push_back(16'hB000 + 16'(i));
    run_pass(3, 16'hC000, 1'b1);
    chk("t3_we1", 64'(n_we1), 64'd3);
    chk("t3_ov", 64'(n_ov), 64'd3);
    chk("t3_q", 64'(exp_q.size()), 64'd0);
    chk("t3_bank", 64'(bank_sel), 64'd1);
    chk("t3_mem2", 64'(mem1[2]), 64'hC002);

    // T4: empty pass
    clr();
    run_pass(0, 16'h0, 1'b0);
    chk("t4_done", 64'(n_done), 64'd1);
    chk("t4_bank", 64'(bank_sel), 64'd1);
    chk("t4_cs", 64'(n_we1 + n_we2 + n_rd_cs), 64'd0);

    // T5: reset after two accepts
    clr();
    exp_q.push_back(16'hC000);
    exp_q.push_back(16'hC001);
    start = 1'b1; len = 11'd4;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 16'hD000;
    @(posedge clk); #1;
    in_data = 16'hD001;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_ctl", 64'({in_ready, out_valid, busy, done, bank_sel, cs1, cs2, oe1, oe2, we1, we2}), 64'd0);
    chk("t5_addr", 64'(addr), 64'd0);
    chk("t5_odata", 64'(out_data), 64'd0);
    chk("t5_z", 64'((data1 === 16'hzzzz) && (data2 === 16'hzzzz)), 64'd1);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_done", 64'(n_done), 64'd0);
    chk("t5_we2", 64'(n_we2), 64'd2);
    chk("t5_q", 64'(exp_q.size()), 64'd0);
    chk("t5_bank", 64'(bank_sel), 64'd0);
    @(posedge clk); #1;

    // T6: full-depth pass
    clr();
    last_wr_addr = -1;
    run_pass(1 << AW, 16'h0000, 1'b0);
    chk("t6_we1", 64'(n_we1), 64'd1024);
    chk("t6_last", 64'(last_wr_addr), 64'd1023);
    chk("t6_ov", 64'(n_ov), 64'd0);
    chk("t6_done", 64'(n_done), 64'd1);
    chk("t6_bank", 64'(bank_sel), 64'd1);
    chk("t6_mem", 64'(mem1[1023]), 64'd1023);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
